// File: rtl/gen_adder_pkg.sv
// Shared mode encodings and elaboration helpers for the pipelined adder family.
// Pure constants and functions: no latency, no flow control.
package gen_adder_pkg;

    localparam int ADD_HALF = 0;
    localparam int ADD_FULL = 1;
    localparam int ADD_SUB  = 2;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// CW-bit combinational ripple chunk used once per pipeline stage.
// Zero latency, no flow control; registered by the enclosing stage.
module adder_slice #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a_chunk,
    input  logic [CW-1:0] b_chunk,
    input  logic          ci,
    output logic [CW-1:0] s_chunk,
    output logic          co
);

    assign {co, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CW{1'b0}}, ci};

endmodule

// File: rtl/gen_pipe_adder.sv
// Carry-pipelined WIDTH-bit add/sub, one CW-bit chunk per stage; latency STAGES cycles, one result/cycle.
// Per-stage valid/enable chain: a stage loads when empty or draining, in_ready is combinational.
module gen_pipe_adder
    import gen_adder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STAGES     = 2,
    parameter int ADDER_TYPE = ADD_FULL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    if (WIDTH < 1 || WIDTH > 64 || STAGES < 1 || STAGES > 8 || STAGES > WIDTH ||
        ADDER_TYPE < ADD_HALF || ADDER_TYPE > ADD_SUB) begin : g_param_check
        $error("gen_pipe_adder: illegal parameters WIDTH=%0d STAGES=%0d ADDER_TYPE=%0d",
               WIDTH, STAGES, ADDER_TYPE);
    end

    // Operands are zero-padded to STAGES*CW so every stage sees a full chunk;
    // when padded, the true carry out lands in sum bit WIDTH.
    localparam int CW = ceil_div(WIDTH, STAGES);
    localparam int PW = CW * STAGES;

    typedef logic [PW-1:0] word_t;

    logic [STAGES-1:0] en;
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    word_t             a_q [STAGES];
    word_t             a_d [STAGES];
    word_t             b_q [STAGES];
    word_t             b_d [STAGES];
    word_t             s_q [STAGES];
    word_t             s_d [STAGES];

    word_t             a_in, b_in;
    logic              c_in0;
    logic [STAGES-1:0] src_v, src_c;
    word_t             src_a [STAGES];
    word_t             src_b [STAGES];
    word_t             src_s [STAGES];
    logic [CW-1:0]     s_chunk [STAGES];
    logic [STAGES-1:0] co;

    always_comb begin
        a_in             = '0;
        b_in             = '0;
        a_in[WIDTH-1:0]  = a;
        b_in[WIDTH-1:0]  = (ADDER_TYPE == ADD_SUB) ? ~b : b;
    end

    assign c_in0 = (ADDER_TYPE == ADD_FULL) ? cin : (ADDER_TYPE == ADD_SUB);

    // A stage may load when it is empty or every stage after it is draining.
    always_comb begin
        logic run;
        en  = '0;
        run = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            run   = run || !v_q[i];
            en[i] = run;
        end
    end

    assign in_ready = en[0];

    always_comb begin
        src_v[0] = in_valid;
        src_c[0] = c_in0;
        src_a[0] = a_in;
        src_b[0] = b_in;
        src_s[0] = '0;
        for (int i = 1; i < STAGES; i++) begin
            src_v[i] = v_q[i-1];
            src_c[i] = c_q[i-1];
            src_a[i] = a_q[i-1];
            src_b[i] = b_q[i-1];
            src_s[i] = s_q[i-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(.CW(CW)) u_slice (
            .a_chunk (src_a[k][k*CW +: CW]),
            .b_chunk (src_b[k][k*CW +: CW]),
            .ci      (src_c[k]),
            .s_chunk (s_chunk[k]),
            .co      (co[k])
        );
    end

    // Payload only moves with a valid transaction, so idle-bus garbage never
    // reaches the registers and a stalled output stays put.
    always_comb begin
        v_d = v_q;
        c_d = c_q;
        a_d = a_q;
        b_d = b_q;
        s_d = s_q;
        for (int i = 0; i < STAGES; i++) begin
            if (en[i]) begin
                v_d[i] = src_v[i];
                if (src_v[i]) begin
                    a_d[i]              = src_a[i];
                    b_d[i]              = src_b[i];
                    s_d[i]              = src_s[i];
                    s_d[i][i*CW +: CW]  = s_chunk[i];
                    c_d[i]              = co[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            a_q <= '{default: '0};
            b_q <= '{default: '0};
            s_q <= '{default: '0};
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1][WIDTH-1:0];

    if (PW > WIDTH) begin : g_cout_pad
        assign cout = c_q[STAGES-1] | s_q[STAGES-1][WIDTH];
    end else begin : g_cout_full
        assign cout = c_q[STAGES-1];
    end

endmodule

// File: tb/tb_gen_pipe_adder.sv
// Scoreboarded bench: a directed 8-bit/2-stage full adder plus randomized streams over several geometries.
module tb_gen_pipe_adder;

    localparam int NCFG     = 9;
    localparam int N_RAND   = 1000;
    localparam int N_PRESET = 8;
    localparam int BUDGET   = 8000;

    logic clk;
    logic m_rst_n;
    logic rst_rand_n;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [NCFG-1:0] done_rand;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_w(input int k);
        case (k)
            0, 1, 2: return 8;
            3, 6:    return 13;
            5:       return 1;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_s(input int k);
        case (k)
            0, 1, 2: return 2;
            3, 7:    return 3;
            4, 6:    return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_t(input int k);
        case (k)
            1, 6:    return 0;
            2, 4, 8: return 2;
            default: return 1;
        endcase
    endfunction

    // Reference: {cout, sum} from plain integer arithmetic modulo 2^w.
    function automatic logic [64:0] model(input int w, input int t, input logic [63:0] a_i,
                                          input logic [63:0] b_i, input logic ci);
        logic [63:0] mask, av, bv;
        logic [64:0] full;
        logic        carry;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        av   = a_i & mask;
        bv   = b_i & mask;
        case (t)
            0:       full = {1'b0, av} + {1'b0, bv};
            1:       full = {1'b0, av} + {1'b0, bv} + {64'd0, ci};
            default: full = {1'b0, av} - {1'b0, bv};
        endcase
        carry = (t == 2) ? (av >= bv) : full[w];
        return {carry, full[63:0] & mask};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [128:0] preset_vec(input int i);
        case (i)
            0:       return {1'b0, 64'h01, 64'hFF};
            1:       return {1'b1, 64'h00, 64'h0F};
            2:       return {1'b1, 64'h01, 64'h0F};
            3:       return {1'b0, 64'h07, 64'h05};
            4:       return {1'b0, 64'h05, 64'h07};
            5:       return {1'b1, {64{1'b1}}, {64{1'b1}}};
            6:       return {1'b0, 64'h00, 64'h00};
            default: return {1'b1, 64'h00, {64{1'b1}}};
        endcase
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string why);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, why);
    endtask

    // ---------------- directed DUT: WIDTH=8, STAGES=2, full add ----------------
    logic       m_in_vld, m_in_rdy, m_cin, m_out_vld, m_out_rdy, m_cout;
    logic [7:0] m_a, m_b, m_sum;
    logic [64:0] m_exp_q [$];

    gen_pipe_adder #(.WIDTH(8), .STAGES(2), .ADDER_TYPE(1)) u_main (
        .clk       (clk),
        .rst_n     (m_rst_n),
        .in_valid  (m_in_vld),
        .in_ready  (m_in_rdy),
        .a         (m_a),
        .b         (m_b),
        .cin       (m_cin),
        .out_valid (m_out_vld),
        .out_ready (m_out_rdy),
        .sum       (m_sum),
        .cout      (m_cout)
    );

    task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic ordy);
        @(negedge clk);
        m_in_vld  = v;
        m_a       = av;
        m_b       = bv;
        m_cin     = ci;
        m_out_rdy = ordy;
        #2;
        if (m_in_vld && m_in_rdy)
            m_exp_q.push_back(model(8, 1, {56'd0, m_a}, {56'd0, m_b}, m_cin));
    endtask

    initial begin : m_mon
        logic [64:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (m_rst_n && m_out_vld) begin
                if (m_exp_q.size() == 0) begin
                    flag("main_unexpected", $sformatf("out_valid with sum %h and nothing expected", m_sum));
                end else if (m_out_rdy) begin
                    e = m_exp_q.pop_front();
                    check("main_out", {m_cout, 56'd0, m_sum}, e);
                end else begin
                    check("main_stall", {m_cout, 56'd0, m_sum}, m_exp_q[0]);
                end
            end
        end
    end

    initial begin : main
        int waited;
        m_rst_n = 1'b1; rst_rand_n = 1'b1; done_rand = '0;
        m_in_vld = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_out_rdy = 1'b1;
        #1;
        m_rst_n = 1'b0; rst_rand_n = 1'b0;
        #2;
        check("rst_out_valid", {64'd0, m_out_vld}, 65'd0);
        check("rst_sum_cout", {m_cout, 56'd0, m_sum}, 65'd0);
        repeat (2) @(negedge clk);
        m_rst_n = 1'b1; rst_rand_n = 1'b1;
        #2;
        check("rst_in_ready", {64'd0, m_in_rdy}, 65'd1);

        // latency and basic full-add results
        step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
        check("t1_in_ready", {64'd0, m_in_rdy}, 65'd1);
        step(1'b1, 8'h0F, 8'h00, 1'b1, 1'b1);
        check("t1_lat_early", {64'd0, m_out_vld}, 65'd0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("t1_lat_exact", {64'd0, m_out_vld}, 65'd1);
        check("t1_res_ff_01", {m_cout, 56'd0, m_sum}, {1'b1, 64'h00});
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("t1_res_0f_00_c", {m_cout, 56'd0, m_sum}, {1'b0, 64'h10});
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // backpressure fill, hold, then simultaneous accept/emit
        step(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
        check("t3_rdy_first", {64'd0, m_in_rdy}, 65'd1);
        step(1'b1, 8'h02, 8'h02, 1'b0, 1'b0);
        check("t3_rdy_second", {64'd0, m_in_rdy}, 65'd1);
        step(1'b1, 8'h03, 8'h03, 1'b0, 1'b0);
        check("t3_full_rdy", {64'd0, m_in_rdy}, 65'd0);
        check("t3_hold_a", {m_cout, 56'd0, m_sum}, {1'b0, 64'h02});
        step(1'b1, 8'h03, 8'h03, 1'b0, 1'b0);
        check("t3_full_rdy2", {64'd0, m_in_rdy}, 65'd0);
        check("t3_hold_b", {m_cout, 56'd0, m_sum}, {1'b0, 64'h02});
        step(1'b1, 8'h03, 8'h03, 1'b0, 1'b1);
        check("t4_simul_rdy", {64'd0, m_in_rdy}, 65'd1);
        check("t3_out_2", {m_cout, 56'd0, m_sum}, {1'b0, 64'h02});
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("t3_out_4", {m_cout, 56'd0, m_sum}, {1'b0, 64'h04});
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("t3_out_6", {m_cout, 56'd0, m_sum}, {1'b0, 64'h06});
        repeat (2) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // asynchronous reset with a full pipe
        step(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        step(1'b1, 8'h30, 8'h40, 1'b1, 1'b0);
        step(1'b1, 8'h50, 8'h50, 1'b0, 1'b0);
        check("t5_full_rdy", {64'd0, m_in_rdy}, 65'd0);
        #1;
        m_rst_n = 1'b0;
        m_exp_q.delete();
        #1;
        check("t5_async_valid", {64'd0, m_out_vld}, 65'd0);
        check("t5_async_sum", {m_cout, 56'd0, m_sum}, 65'd0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        m_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            check($sformatf("t5_no_stale_%0d", i), {64'd0, m_out_vld}, 65'd0);
        end
        step(1'b1, 8'hAA, 8'h55, 1'b1, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("t5_new_result", {m_cout, 56'd0, m_sum}, {1'b1, 64'h00});
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        waited = 0;
        while (done_rand != {NCFG{1'b1}} && waited < BUDGET + 200) begin
            @(negedge clk);
            waited++;
        end
        if (done_rand != {NCFG{1'b1}})
            flag("rand_done", $sformatf("random streams unfinished, done mask %b", done_rand));
        check("main_drain", 65'(m_exp_q.size()), 65'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- randomized streams over several geometries ----------------
    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = cfg_w(g);
        localparam int S = cfg_s(g);
        localparam int T = cfg_t(g);

        logic         r_in_vld, r_in_rdy, r_cin, r_out_vld, r_out_rdy, r_cout;
        logic [W-1:0] r_a, r_b, r_sum;
        logic [64:0]  r_exp_q [$];

        gen_pipe_adder #(.WIDTH(W), .STAGES(S), .ADDER_TYPE(T)) u_dut (
            .clk       (clk),
            .rst_n     (rst_rand_n),
            .in_valid  (r_in_vld),
            .in_ready  (r_in_rdy),
            .a         (r_a),
            .b         (r_b),
            .cin       (r_cin),
            .out_valid (r_out_vld),
            .out_ready (r_out_rdy),
            .sum       (r_sum),
            .cout      (r_cout)
        );

        initial begin : drv
            int          sent, cycles;
            logic        acc;
            logic [63:0] ra, rb;
            logic [128:0] pv;
            sent = 0; cycles = 0; acc = 1'b0;
            r_in_vld = 1'b0; r_a = '0; r_b = '0; r_cin = 1'b0;
            @(posedge rst_rand_n);
            while (sent < N_RAND && cycles < BUDGET) begin
                @(negedge clk);
                cycles++;
                if (acc) r_in_vld = 1'b0;
                if (!r_in_vld) begin
                    ra = rnd64();
                    rb = rnd64();
                    r_cin = 1'($urandom_range(0, 1));
                    if (sent < N_PRESET) begin
                        pv = preset_vec(sent);
                        ra = pv[63:0];
                        rb = pv[127:64];
                        r_cin = pv[128];
                        r_in_vld = 1'b1;
                    end else if ($urandom_range(0, 3) != 0) begin
                        r_in_vld = 1'b1;
                    end
                    r_a = ra[W-1:0];
                    r_b = rb[W-1:0];
                end
                #2;
                acc = r_in_vld && r_in_rdy;
                if (acc) begin
                    r_exp_q.push_back(model(W, T, 64'(r_a), 64'(r_b), r_cin));
                    sent++;
                end
            end
            @(negedge clk);
            r_in_vld = 1'b0;
            if (sent < N_RAND)
                flag($sformatf("cfg%0d_input_timeout", g), $sformatf("only %0d of %0d accepted", sent, N_RAND));
        end

        initial begin : mon
            int          got, cycles;
            logic [64:0] e;
            got = 0; cycles = 0;
            r_out_rdy = 1'b0;
            @(posedge rst_rand_n);
            while (got < N_RAND && cycles < BUDGET) begin
                @(negedge clk);
                cycles++;
                r_out_rdy = ($urandom_range(0, 2) != 0);
                #2;
                if (r_out_vld) begin
                    if (r_exp_q.size() == 0) begin
                        flag($sformatf("cfg%0d_unexpected", g), "out_valid with nothing expected");
                        if (r_out_rdy) got++;
                    end else if (r_out_rdy) begin
                        e = r_exp_q.pop_front();
                        check($sformatf("cfg%0d_out", g), {r_cout, 64'(r_sum)}, e);
                        got++;
                    end else begin
                        check($sformatf("cfg%0d_stall", g), {r_cout, 64'(r_sum)}, r_exp_q[0]);
                    end
                end
            end
            if (got < N_RAND)
                flag($sformatf("cfg%0d_output_timeout", g), $sformatf("only %0d of %0d results seen", got, N_RAND));
            done_rand[g] = 1'b1;
        end
    end

endmodule
